// File: rtl/skew_pkg.sv
// ============================================================================
// skew_pkg: shared FSM states, mode encodings and lane-slice helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package skew_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic MODE_SKEW   = 1'b0;
    localparam logic MODE_DESKEW = 1'b1;

    function automatic int lane_lsb(input int lane, input int wl);
        return lane * wl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/skew_deskew_buffer_if.sv
// ============================================================================
// skew_deskew_buffer_if: data/handshake/mode bundle of the deskew buffer.
// Rev 1.0
// ============================================================================
`default_nettype none

interface skew_deskew_buffer_if #(
    parameter int WL    = 8,
    parameter int LANES = 8
);
    logic                en;
    logic                flush;
    logic                mode_req;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*WL-1:0] din;
    logic [LANES*WL-1:0] dout;
    logic [LANES-1:0]    out_valid;
    logic                mode_cur;
    logic                busy;

    modport master (
        output en, flush, mode_req, in_valid, din,
        input  in_ready, dout, out_valid, mode_cur, busy
    );

    modport slave (
        input  en, flush, mode_req, in_valid, din,
        output in_ready, dout, out_valid, mode_cur, busy
    );
endinterface

`default_nettype wire

// File: rtl/skew_lane.sv
// ============================================================================
// skew_lane: one WL+1-bit stallable delay chain with a runtime output tap.
// Rev 1.0
// ============================================================================
`default_nettype none

module skew_lane #(
    parameter int WL    = 8,
    parameter int DEPTH = 7,
    parameter int TAP_W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic             flush,
    input  wire logic             shift_valid,
    input  wire logic [WL-1:0]    din,
    input  wire logic [TAP_W-1:0] tap,
    output logic      [WL-1:0]    dout,
    output logic                  out_valid,
    output logic                  any_valid
);
    logic [DEPTH:1] r_valid;
    logic [WL-1:0]  r_data [1:DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (en) begin
            r_valid[1] <= shift_valid;
            r_data[1]  <= din;
            for (int k = 2; k <= DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    // Tap 0 is a combinational bypass; delayed taps only strobe on advancing cycles.
    always_comb begin
        dout      = din;
        out_valid = shift_valid;
        for (int k = 1; k <= DEPTH; k++) begin
            if (int'(tap) == k) begin
                dout      = r_data[k];
                out_valid = r_valid[k] & en & ~flush;
            end
        end
    end

    assign any_valid = |r_valid;

endmodule

`default_nettype wire

// File: rtl/skew_deskew_buffer.sv
// ============================================================================
// skew_deskew_buffer: per-lane skew/deskew stage with drain-safe mode switch.
// Rev 1.0
// ============================================================================
`default_nettype none

module skew_deskew_buffer
    import skew_pkg::*;
#(
    parameter int WL       = 8,
    parameter int LANES    = 8,
    parameter bit MODE_RST = 1'b0
) (
    input wire logic            clk,
    input wire logic            rst,
    skew_deskew_buffer_if.slave bus
);
    localparam int TAP_W = $clog2(LANES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mode;
    logic                w_mode_nxt;
    logic                w_in_ready;
    logic                w_acc;
    logic [LANES-1:0]    w_lane_any;
    logic [LANES-1:0]    w_out_valid;
    logic [LANES*WL-1:0] w_dout;

    assign w_in_ready = (r_state == RUN);
    assign w_acc      = bus.in_valid & w_in_ready & bus.en;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [TAP_W-1:0] w_tap;

        assign w_tap = (r_mode == MODE_DESKEW) ? TAP_W'(LANES - 1 - i) : TAP_W'(i);

        skew_lane #(
            .WL    (WL),
            .DEPTH (LANES - 1),
            .TAP_W (TAP_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .en          (bus.en),
            .flush       (bus.flush),
            .shift_valid (w_acc),
            .din         (bus.din[lane_lsb(i, WL) +: WL]),
            .tap         (w_tap),
            .dout        (w_dout[lane_lsb(i, WL) +: WL]),
            .out_valid   (w_out_valid[i]),
            .any_valid   (w_lane_any[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_mode  <= MODE_RST;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Mode only changes in SWITCH, after every in-flight valid has left the chains.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        if (bus.flush) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN:     if (bus.mode_req != r_mode) w_state_nxt = DRAIN;
                DRAIN:   if (!(|w_lane_any)) w_state_nxt = SWITCH;
                SWITCH: begin
                    w_mode_nxt  = bus.mode_req;
                    w_state_nxt = RUN;
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != RUN);
    assign bus.mode_cur  = r_mode;
    assign bus.dout      = w_dout;
    assign bus.out_valid = w_out_valid;

endmodule

`default_nettype wire
